ps2_rx: RTL and testbench

- PS/2 device-to-host serial receiver. Deserialises keyboard frames into 8-bit scan codes.
- Sits between the board PS/2 pins and the scan-code-to-7-segment decoder.
- Feeds that decoder a held scan-code byte, plus a one-cycle valid strobe and make/break/extended qualifiers.
- Filters the slow, noisy keyboard clock and recovers from truncated frames.

---
 rtl/ps2_pkg.sv | 16 +
 rtl/ps2_clk_filter.sv | 61 ++++++
 rtl/ps2_rx.sv | 208 ++++++++++++++++++++
 tb/tb_ps2_rx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receiver.
// Optional build macro PS2_RX_MAKE_FILTER_EN (see ps2_rx.sv).
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;
  localparam int         PS2_DATA_BITS    = 8;

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 pin synchroniser and keyboard-clock debounce.
// Emits a one-cycle sample_evt on each filtered clock fall.
module ps2_clk_filter
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic sample_evt,
  output logic sync_data
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] LIM = CW'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic [CW-1:0]          cnt;
  logic                   filt;
  logic                   filt_d;
  logic                   s_clk;

  assign s_clk     = clk_sync[SYNC_STAGES-1];
  assign sync_data = dat_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  // cnt counts consecutive samples disagreeing with filt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      filt   <= 1'b1;
      filt_d <= 1'b1;
    end else begin
      filt_d <= filt;
      if (s_clk == filt) begin
        cnt <= '0;
      end else if (cnt == LIM) begin
        filt <= s_clk;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign sample_evt = filt_d & ~filt;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: scan code, valid strobe, qualifiers.
// PS2_RX_MAKE_FILTER_EN: report key presses only, break_flag tied low.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       break_flag,
  output logic       extended,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    LAST = 3'(PS2_DATA_BITS - 1);

  ps2_state_t state, state_n;

  logic          sample_evt;
  logic          sync_data;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tcnt;
  logic          pend_ext;
  logic          pend_brk;

  logic start_en;
  logic shift_en;
  logic par_en;
  logic fin;
  logic tout;
  logic perr_n;
  logic ferr_n;
  logic accept;
  logic is_ext;
  logic is_brk;

  ps2_clk_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_filt (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .sample_evt (sample_evt),
    .sync_data  (sync_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    start_en = 1'b0;
    shift_en = 1'b0;
    par_en   = 1'b0;
    fin      = 1'b0;
    tout     = 1'b0;
    unique case (state)
      IDLE: begin
        if (sample_evt && !sync_data) begin
          start_en = 1'b1;
          state_n  = DATA;
        end
      end
      DATA: begin
        if (sample_evt) begin
          shift_en = 1'b1;
          if (bit_cnt == LAST) state_n = PARITY;
        end
      end
      PARITY: begin
        if (sample_evt) begin
          par_en  = 1'b1;
          state_n = STOP;
        end
      end
      STOP: begin
        if (sample_evt) begin
          fin     = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // a coincident sample event clears the counter instead
    if (state != IDLE && !sample_evt && tcnt == TLIM) begin
      tout     = 1'b1;
      state_n  = IDLE;
      start_en = 1'b0;
      shift_en = 1'b0;
      par_en   = 1'b0;
      fin      = 1'b0;
    end
  end

  assign ferr_n = tout | (fin & ~sync_data);
  assign perr_n = fin & sync_data & ~(^{shreg, par_bit});
  assign accept = fin & sync_data & (^{shreg, par_bit});
  assign is_ext = shreg == PS2_PREFIX_EXT;
  assign is_brk = shreg == PS2_PREFIX_BREAK;
  assign busy   = state != IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      tcnt    <= '0;
    end else begin
      if (start_en) bit_cnt <= '0;
      if (shift_en) begin
        shreg   <= {sync_data, shreg[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (par_en) par_bit <= sync_data;
      if (state == IDLE || sample_evt) tcnt <= '0;
      else                             tcnt <= tcnt + 1'b1;
    end
  end

`ifdef PS2_RX_MAKE_FILTER_EN
  assign break_flag = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code       <= '0;
      code_valid <= 1'b0;
      extended   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      pend_ext   <= 1'b0;
      pend_brk   <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      parity_err <= perr_n;
      frame_err  <= ferr_n;
      if (perr_n || ferr_n) begin
        pend_ext <= 1'b0;
        pend_brk <= 1'b0;
      end else if (accept) begin
        if (is_ext) begin
          pend_ext <= 1'b1;
        end else if (is_brk) begin
          pend_brk <= 1'b1;
        end else begin
          if (!pend_brk) begin
            code       <= shreg;
            code_valid <= 1'b1;
            extended   <= pend_ext;
          end
          pend_ext <= 1'b0;
          pend_brk <= 1'b0;
        end
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code       <= '0;
      code_valid <= 1'b0;
      break_flag <= 1'b0;
      extended   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      pend_ext   <= 1'b0;
      pend_brk   <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      parity_err <= perr_n;
      frame_err  <= ferr_n;
      if (perr_n || ferr_n) begin
        pend_ext <= 1'b0;
        pend_brk <= 1'b0;
      end else if (accept) begin
        code       <= shreg;
        code_valid <= 1'b1;
        if (is_ext) begin
          pend_ext <= 1'b1;
        end else if (is_brk) begin
          pend_brk <= 1'b1;
        end else begin
          extended   <= pend_ext;
          break_flag <= pend_brk;
          pend_ext   <= 1'b0;
          pend_brk   <= 1'b0;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: frames, prefixes, errors, glitch, timeout.
// Expectations follow PS2_RX_MAKE_FILTER_EN when defined.
module tb_ps2_rx;

  localparam int TMO = 600;
  localparam int H   = 40;

  logic       clk;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] code;
  logic       code_valid;
  logic       break_flag;
  logic       extended;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int nv    = 0;
  int npe   = 0;
  int nfe   = 0;
  int t_fall = 0;
  int v0, p0, f0, dt;
  bit seen;

  ps2_rx #(
    .SYNC_STAGES    (2),
    .FILTER_LEN     (8),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .code       (code),
    .code_valid (code_valid),
    .break_flag (break_flag),
    .extended   (extended),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // high-cycle counts, so a stretched pulse shows up as 2
  always @(negedge clk) begin
    if (code_valid === 1'b1) nv  <= nv + 1;
    if (parity_err === 1'b1) npe <= npe + 1;
    if (frame_err === 1'b1)  nfe <= nfe + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d,
                                     input bit pflip,
                                     input bit stop);
    logic p;
    p = ~(^d) ^ pflip;
    return {stop, p, d, 1'b0};
  endfunction

  task automatic send(input logic [10:0] bits, input int n,
                      input int glitch_bit);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      if (i == glitch_bit) begin
        repeat (H / 2) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        ps2_clk = 1'b1;
        repeat (H / 2 - 3) @(posedge clk);
      end else begin
        repeat (H) @(posedge clk);
      end
      ps2_clk = 1'b0;
      t_fall  = cyc;
      repeat (H) @(posedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (H) @(posedge clk);
  endtask

  task automatic snap();
    @(negedge clk);
    v0 = nv;
    p0 = npe;
    f0 = nfe;
  endtask

  initial begin
    rst_n    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_code", code, 8'h00);
    chk("rst_valid", code_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_brk", break_flag, 1'b0);
    chk("rst_ext", extended, 1'b0);
    chk("rst_errs", {parity_err, frame_err}, 2'b00);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    snap();
    send(mk(8'h1C, 0, 1), 11, -1);
    @(negedge clk);
    chk("1c_code", code, 8'h1C);
    chk("1c_nvalid", nv - v0, 1);
    chk("1c_flags", {break_flag, extended}, 2'b00);

    snap();
    send(mk(8'hF0, 0, 1), 11, -1);
    @(negedge clk);
`ifdef PS2_RX_MAKE_FILTER_EN
    chk("f0_code", code, 8'h1C);
    chk("f0_nvalid", nv - v0, 0);
`else
    chk("f0_code", code, 8'hF0);
    chk("f0_nvalid", nv - v0, 1);
    chk("f0_brk", break_flag, 1'b0);
`endif
    send(mk(8'h1C, 0, 1), 11, -1);
    @(negedge clk);
    chk("brk_code", code, 8'h1C);
`ifdef PS2_RX_MAKE_FILTER_EN
    chk("brk_nvalid", nv - v0, 0);
    chk("brk_flag", break_flag, 1'b0);
`else
    chk("brk_nvalid", nv - v0, 2);
    chk("brk_flag", break_flag, 1'b1);
`endif

    snap();
    send(mk(8'hE0, 0, 1), 11, -1);
    send(mk(8'h75, 0, 1), 11, -1);
    @(negedge clk);
    chk("ext_code", code, 8'h75);
    chk("ext_flags", {break_flag, extended}, 2'b01);
`ifdef PS2_RX_MAKE_FILTER_EN
    chk("ext_nvalid", nv - v0, 1);
`else
    chk("ext_nvalid", nv - v0, 2);
`endif

    snap();
    send(mk(8'h45, 1, 1), 11, -1);
    @(negedge clk);
    chk("par_npe", npe - p0, 1);
    chk("par_nvalid", nv - v0, 0);
    chk("par_code", code, 8'h75);
    send(mk(8'h45, 0, 1), 11, -1);
    @(negedge clk);
    chk("par_ok_code", code, 8'h45);
    chk("par_ok_nvalid", nv - v0, 1);
    chk("par_ok_ext", extended, 1'b0);

    snap();
    send(mk(8'h16, 0, 0), 11, 4);
    @(negedge clk);
    chk("stop_nfe", nfe - f0, 1);
    chk("stop_nvalid", nv - v0, 0);
    chk("stop_npe", npe - p0, 0);
    chk("stop_code", code, 8'h45);

    snap();
    send(mk(8'h29, 0, 1), 11, 3);
    @(negedge clk);
    chk("glitch_code", code, 8'h29);
    chk("glitch_nvalid", nv - v0, 1);
    chk("glitch_nfe", nfe - f0, 0);

    snap();
    send(mk(8'hA5, 0, 1), 5, -1);
    @(negedge clk);
    chk("tmo_busy", busy, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 3 * TMO; i++) begin
      @(negedge clk);
      if (frame_err === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    dt = cyc - t_fall;
    chk("tmo_seen", seen, 1'b1);
    chk("tmo_not_early", dt >= TMO, 1'b1);
    chk("tmo_not_late", dt <= TMO + 20, 1'b1);
    @(negedge clk);
    chk("tmo_idle", busy, 1'b0);
    chk("tmo_nfe", nfe - f0, 1);
    chk("tmo_nvalid", nv - v0, 0);

    snap();
    send(mk(8'h16, 0, 1), 11, -1);
    @(negedge clk);
    chk("post_code", code, 8'h16);
    chk("post_nvalid", nv - v0, 1);
    chk("post_flags", {break_flag, extended}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
